traffic_phase_ctrl: RTL and testbench

Parametrised N-phase intersection controller; generation after the fixed 2-direction NS/EW sequencer. Cycles round-robin through NUM_PHASES approaches: optional protected LEFT, then GREEN, YELLOW, and an ALL-RED clearance between phases. Runtime-programmable durations, tick-based timing, demand-driven phase skipping and a flash (fault/night) mode. Drives the per-approach lamp driver bus.

---
 rtl/traffic_phase_ctrl.sv | 158 +++++++++++++++
 tb/tb_traffic_phase_ctrl.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/traffic_phase_ctrl.sv
// traffic_phase_ctrl: N-phase round-robin intersection controller (LEFT/GREEN/YELLOW/ALL-RED, skip, flash).
// Define TRAFFIC_PED_EN to add sticky pedestrian requests and per-phase walk outputs.
module traffic_phase_ctrl #(
  parameter int NUM_PHASES = 4,
  parameter int CNT_W = 8,
  localparam int PW = $clog2(NUM_PHASES)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    tick,
  input  logic [CNT_W-1:0]        cfg_left,
  input  logic [CNT_W-1:0]        cfg_green,
  input  logic [CNT_W-1:0]        cfg_yellow,
  input  logic [CNT_W-1:0]        cfg_allred,
  input  logic                    skip_en,
  input  logic [NUM_PHASES-1:0]   veh_req,
  input  logic                    flash_req,
  output logic [2*NUM_PHASES-1:0] lights,
  output logic [PW-1:0]           phase_idx,
  output logic                    phase_start,
  output logic                    in_flash
`ifdef TRAFFIC_PED_EN
  ,
  input  logic [NUM_PHASES-1:0]   ped_req,
  output logic [NUM_PHASES-1:0]   walk
`endif
);
  typedef enum logic [2:0] {S_ALLRED, S_LEFT, S_GREEN, S_YELLOW, S_FLASH} state_t;
  localparam logic [1:0] L_GRN = 2'd0, L_YEL = 2'd1, L_RED = 2'd2, L_LFT = 2'd3;

  state_t r_state, w_ns;
  logic [CNT_W-1:0] r_cnt, r_dur, w_dur, w_ncnt, w_ndur;
  logic r_init, r_tog, w_ntog, w_exp, w_found, w_ps;
  logic [PW-1:0] w_sel, w_nidx;
  logic [NUM_PHASES-1:0] w_dem;

  function automatic logic [CNT_W-1:0] nz(input logic [CNT_W-1:0] d);
    return d == '0 ? CNT_W'(1) : d;
  endfunction

  function automatic logic [2*NUM_PHASES-1:0] lamp(input state_t s, input logic [PW-1:0] p, input logic t);
    logic [2*NUM_PHASES-1:0] v;
    v = '0;
    for (int i = 0; i < NUM_PHASES; i++)
      v[2*i +: 2] = s == S_FLASH ? (t ? L_YEL : L_RED) :
                    PW'(i) != p  ? L_RED :
                    s == S_LEFT  ? L_LFT :
                    s == S_GREEN ? L_GRN :
                    s == S_YELLOW ? L_YEL : L_RED;
    return v;
  endfunction

  always_comb begin
    // r_init covers the first edge after reset, when cfg_allred has not been latched yet
    w_dur = r_init ? nz(cfg_allred) : r_dur;
    w_exp = tick && (r_cnt == w_dur - 1'b1);
    w_found = 1'b0;
    w_sel = phase_idx;
    for (int k = NUM_PHASES; k >= 1; k--)
      if (skip_en ? w_dem[(int'(phase_idx) + k) % NUM_PHASES] : k == 1) begin
        w_found = 1'b1;
        w_sel = PW'((int'(phase_idx) + k) % NUM_PHASES);
      end
    w_ns = r_state;
    w_nidx = phase_idx;
    w_ndur = w_dur;
    w_ntog = r_tog;
    w_ps = 1'b0;
    w_ncnt = tick ? r_cnt + 1'b1 : r_cnt;
    case (r_state)
      S_ALLRED: if (w_exp) begin
        // without a candidate cnt parks at its final value so every tick re-evaluates
        w_ncnt = r_cnt;
        if (flash_req) begin
          w_ns = S_FLASH;
          w_ntog = 1'b1;
          w_ncnt = '0;
        end else if (w_found) begin
          w_ns = cfg_left != '0 ? S_LEFT : S_GREEN;
          w_ndur = cfg_left != '0 ? cfg_left : nz(cfg_green);
          w_nidx = w_sel;
          w_ps = 1'b1;
          w_ncnt = '0;
        end
      end
      S_LEFT: if (w_exp) begin
        w_ns = S_GREEN;
        w_ndur = nz(cfg_green);
        w_ncnt = '0;
      end
      S_GREEN: if (w_exp) begin
        w_ns = S_YELLOW;
        w_ndur = nz(cfg_yellow);
        w_ncnt = '0;
      end
      S_YELLOW: if (w_exp) begin
        w_ns = S_ALLRED;
        w_ndur = nz(cfg_allred);
        w_ncnt = '0;
      end
      S_FLASH: begin
        w_ncnt = '0;
        if (tick) begin
          if (flash_req) begin
            w_ntog = ~r_tog;
          end else begin
            w_ns = S_ALLRED;
            w_ndur = nz(cfg_allred);
          end
        end
      end
      default: w_ns = S_ALLRED;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state <= S_ALLRED;
      r_cnt <= '0;
      r_dur <= '0;
      r_init <= 1'b1;
      r_tog <= 1'b0;
      phase_idx <= PW'(NUM_PHASES - 1);
      lights <= {NUM_PHASES{L_RED}};
      phase_start <= 1'b0;
      in_flash <= 1'b0;
    end else begin
      r_state <= w_ns;
      r_cnt <= w_ncnt;
      r_dur <= w_ndur;
      r_init <= 1'b0;
      r_tog <= w_ntog;
      phase_idx <= w_nidx;
      lights <= lamp(w_ns, w_nidx, w_ntog);
      phase_start <= w_ps;
      in_flash <= w_ns == S_FLASH;
    end

`ifdef TRAFFIC_PED_EN
  logic [NUM_PHASES-1:0] r_ped, w_oh, w_pend;
  logic w_grn_in;
  assign w_pend = r_ped | ped_req;
  assign w_dem = veh_req | w_pend;
  assign w_grn_in = w_ns == S_GREEN && r_state != S_GREEN;
  assign w_oh = NUM_PHASES'(1) << w_nidx;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_ped <= '0;
      walk <= '0;
    end else begin
      r_ped <= w_pend & ~(w_grn_in ? w_oh : '0);
      walk <= w_grn_in ? (w_pend & w_oh) : (w_ns == S_GREEN ? walk : '0);
    end
`else
  assign w_dem = veh_req;
`endif
endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// tb_traffic_phase_ctrl: scoreboard bench for traffic_phase_ctrl with a countdown reference model.
module tb_traffic_phase_ctrl;
  localparam int AR = 0, LF = 1, GR = 2, YE = 3, FL = 4;

  logic clk = 0;
  logic rst_n = 1;
  logic tick = 1;
  logic [7:0] cfg_left = 2, cfg_green = 5, cfg_yellow = 3, cfg_allred = 1;
  logic skip_en = 0;
  logic [3:0] veh_req = 0;
  logic flash_req = 0;
  logic [7:0] lights;
  logic [1:0] phase_idx;
  logic phase_start, in_flash;

  int n_vec = 0, n_err = 0;
  int m_st = AR, m_idx = 3, m_rem = 0;
  bit m_tog = 0, m_ps = 0, m_init = 1;
  int left_seen = 0;
  logic [11:0] sb[$];
  int ps_log[$];

  traffic_phase_ctrl #(.NUM_PHASES(4), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .tick(tick),
    .cfg_left(cfg_left), .cfg_green(cfg_green), .cfg_yellow(cfg_yellow), .cfg_allred(cfg_allred),
    .skip_en(skip_en), .veh_req(veh_req), .flash_req(flash_req),
    .lights(lights), .phase_idx(phase_idx), .phase_start(phase_start), .in_flash(in_flash)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  function automatic int nz(input logic [7:0] d);
    return d == 0 ? 1 : int'(d);
  endfunction

  function automatic logic [7:0] m_lamps(input int st, input int idx, input bit tog);
    logic [7:0] v;
    logic [1:0] c;
    v = 0;
    for (int i = 0; i < 4; i++) begin
      if (st == FL) c = tog ? 2'd1 : 2'd2;
      else if (i != idx) c = 2'd2;
      else c = st == LF ? 2'd3 : st == GR ? 2'd0 : st == YE ? 2'd1 : 2'd2;
      v[2*i +: 2] = c;
    end
    return v;
  endfunction

  task automatic model_step();
    int nxt;
    m_ps = 0;
    if (m_init) begin
      m_rem = nz(cfg_allred);
      m_init = 0;
    end
    if (!tick) return;
    if (m_st == FL) begin
      if (!flash_req) begin
        m_st = AR;
        m_rem = nz(cfg_allred);
      end else m_tog = !m_tog;
      return;
    end
    m_rem--;
    if (m_rem > 0) return;
    case (m_st)
      AR: if (flash_req) begin
        m_st = FL;
        m_tog = 1;
      end else begin
        nxt = -1;
        for (int k = 1; k <= 4; k++)
          if (nxt < 0 && (skip_en ? veh_req[(m_idx + k) % 4] : k == 1)) nxt = (m_idx + k) % 4;
        if (nxt < 0) m_rem = 1;
        else begin
          m_idx = nxt;
          m_ps = 1;
          if (cfg_left != 0) begin m_st = LF; m_rem = int'(cfg_left); end
          else begin m_st = GR; m_rem = nz(cfg_green); end
        end
      end
      LF: begin m_st = GR; m_rem = nz(cfg_green); end
      GR: begin m_st = YE; m_rem = nz(cfg_yellow); end
      default: begin m_st = AR; m_rem = nz(cfg_allred); end
    endcase
  endtask

  task automatic cycle();
    logic [11:0] e;
    model_step();
    sb.push_back({m_lamps(m_st, m_idx, m_tog), 2'(m_idx), m_ps, m_st == FL});
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk("cycle", {lights, phase_idx, phase_start, in_flash}, e);
    if (phase_start) ps_log.push_back(int'(phase_idx));
    for (int i = 0; i < 4; i++) if (lights[2*i +: 2] == 2'd3) left_seen++;
  endtask

  task automatic run(input int n);
    repeat (n) cycle();
  endtask

  task automatic wait_state(input int st, input int idx);
    int n = 0;
    while (!(m_st == st && (idx < 0 || m_idx == idx)) && n < 200) begin
      cycle();
      n++;
    end
    chk("wait_bound", n < 200, 1);
  endtask

  task automatic do_reset();
    rst_n = 0;
    #2;
    chk("rst_lights", lights, 8'hAA);
    chk("rst_idx", phase_idx, 3);
    chk("rst_flash", in_flash, 0);
    chk("rst_start", phase_start, 0);
    m_st = AR; m_idx = 3; m_tog = 0; m_ps = 0; m_init = 1;
    rst_n = 1;
  endtask

  initial begin
    #1;
    do_reset();
    run(50);
    chk("seq_len", ps_log.size() >= 5, 1);
    for (int i = 0; i < 5 && i < ps_log.size(); i++) chk($sformatf("seq%0d", i), ps_log[i], i % 4);

    cfg_left = 0;
    wait_state(AR, -1);
    left_seen = 0;
    run(30);
    chk("no_left", left_seen, 0);

    cfg_left = 2;
    do_reset();
    skip_en = 1;
    veh_req = 4'b0001;
    wait_state(GR, 0);
    veh_req = 4'b0100;
    ps_log.delete();
    run(15);
    chk("skip_to2", ps_log.size() > 0 ? ps_log[0] : -1, 2);
    veh_req = 0;
    run(30);
    chk("held_red", lights, 8'hAA);
    veh_req = 4'b0010;
    ps_log.delete();
    run(10);
    chk("resume1", ps_log.size() > 0 ? ps_log[0] : -1, 1);

    skip_en = 0;
    veh_req = 0;
    wait_state(GR, -1);
    flash_req = 1;
    run(25);
    chk("flash_on", in_flash, 1);
    flash_req = 0;
    run(20);

    wait_state(GR, -1);
    tick = 0;
    run(10);
    cfg_green = 7;
    run(10);
    tick = 1;
    run(40);
    cfg_green = 5;

    for (int i = 0; i < 80; i++) begin
      tick = 1'($urandom_range(0, 1));
      if (i % 10 == 0) begin
        skip_en = 1'($urandom_range(0, 1));
        veh_req = 4'($urandom_range(0, 15));
        flash_req = $urandom_range(0, 5) == 0;
      end
      cycle();
    end
    tick = 1;
    flash_req = 0;
    skip_en = 0;

    wait_state(YE, 2);
    do_reset();
    ps_log.delete();
    run(15);
    chk("post_rst0", ps_log.size() > 0 ? ps_log[0] : -1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
